// File: rtl/bsg_tiehi_seq_if.sv
// Control/status bundle for the staged tie-high sequencer.
// BSG_TIEHI_SEQ_STAGE_OUT_EN adds the released-stage count stage_o.
interface bsg_tiehi_seq_if #(
    parameter int width_p = 128,
    parameter int group_p = 16
);
    localparam int stages_lp  = (width_p + group_p - 1) / group_p;
    localparam int stage_w_lp = $clog2(stages_lp + 1);

    logic               en_i;
    logic               clear_i;
    logic [width_p-1:0] o;
    logic               busy_o;
    logic               done_o;
`ifdef BSG_TIEHI_SEQ_STAGE_OUT_EN
    logic [stage_w_lp-1:0] stage_o;

    modport master (output en_i, clear_i, input o, busy_o, done_o, stage_o);
    modport slave  (input en_i, clear_i, output o, busy_o, done_o, stage_o);
`else
    modport master (output en_i, clear_i, input o, busy_o, done_o);
    modport slave  (input en_i, clear_i, output o, busy_o, done_o);
`endif
endinterface

// File: rtl/bsg_tiehi_seq.sv
// Releases a tie-high vector group_p bits at a time, one group every delay_p cycles.
// BSG_TIEHI_SEQ_STAGE_OUT_EN adds stage_o, the count of released groups.
module bsg_tiehi_seq #(
    parameter int width_p = 128,
    parameter int group_p = 16,
    parameter int delay_p = 8
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    bsg_tiehi_seq_if.slave sif
);
    localparam int stages_lp = (width_p + group_p - 1) / group_p;
    localparam int scw_lp    = (stages_lp > 1) ? $clog2(stages_lp) : 1;
    localparam int dcw_lp    = (delay_p > 1) ? $clog2(delay_p) : 1;

    localparam logic [scw_lp-1:0] last_stage_lp = scw_lp'(stages_lp - 1);
    localparam logic [dcw_lp-1:0] reload_lp     = dcw_lp'(delay_p - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [dcw_lp-1:0]   delay_q, delay_d;
    logic [scw_lp-1:0]   stage_q, stage_d;
    logic [width_p-1:0]  o_q, o_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

`ifdef BSG_TIEHI_SEQ_STAGE_OUT_EN
    localparam int rcw_lp = $clog2(stages_lp + 1);
    logic [rcw_lp-1:0]   released_q, released_d;
`endif

    // Bits owned by stage k; shifts past the top fall off, so a short final
    // group never reaches beyond width_p-1.
    function automatic logic [width_p-1:0] stage_mask(input int k);
        logic [width_p-1:0] lo;
        logic [width_p-1:0] hi;
        lo = {width_p{1'b1}} << (k * group_p);
        hi = {width_p{1'b1}} << ((k + 1) * group_p);
        return lo & ~hi;
    endfunction

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            delay_q <= '0;
            stage_q <= '0;
            o_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BSG_TIEHI_SEQ_STAGE_OUT_EN
            released_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            stage_q <= stage_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BSG_TIEHI_SEQ_STAGE_OUT_EN
            released_q <= released_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        stage_d = stage_q;
        o_d     = o_q;
`ifdef BSG_TIEHI_SEQ_STAGE_OUT_EN
        released_d = released_q;
`endif

        case (state_q)
            IDLE: begin
                if (sif.en_i) begin
                    state_d = WAIT;
                    delay_d = reload_lp;
                    stage_d = '0;
                end
            end
            WAIT: begin
                if (delay_q == '0) begin
                    delay_d = reload_lp;
                    o_d     = o_q | stage_mask(int'(stage_q));
`ifdef BSG_TIEHI_SEQ_STAGE_OUT_EN
                    released_d = released_q + 1'b1;
`endif
                    if (stage_q == last_stage_lp) begin
                        state_d = DONE;
                        o_d     = '1;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    delay_d = delay_q - 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                o_d     = '0;
            end
        endcase

        // Re-tie wins over a start request and over a release in the same cycle.
        if (sif.clear_i) begin
            state_d = IDLE;
            delay_d = '0;
            stage_d = '0;
            o_d     = '0;
`ifdef BSG_TIEHI_SEQ_STAGE_OUT_EN
            released_d = '0;
`endif
        end

        busy_d = (state_d == WAIT);
        done_d = (state_d == DONE);
    end

    assign sif.o      = o_q;
    assign sif.busy_o = busy_q;
    assign sif.done_o = done_q;
`ifdef BSG_TIEHI_SEQ_STAGE_OUT_EN
    assign sif.stage_o = released_q;
`endif

endmodule

// File: tb/tb_bsg_tiehi_seq.sv
// Bench for bsg_tiehi_seq: a default-size instance and a 20/8/1 instance driven side by side.
// Checks stage_o as well when BSG_TIEHI_SEQ_STAGE_OUT_EN is defined.
module tb_bsg_tiehi_seq;
    localparam int WA = 128, GA = 16, DA = 8, SA = 8;
    localparam int WB = 20,  GB = 8,  DB = 1, SB = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bsg_tiehi_seq_if #(.width_p(WA), .group_p(GA)) aif ();
    bsg_tiehi_seq_if #(.width_p(WB), .group_p(GB)) bif ();

    bsg_tiehi_seq #(.width_p(WA), .group_p(GA), .delay_p(DA)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .sif(aif.slave));
    bsg_tiehi_seq #(.width_p(WB), .group_p(GB), .delay_p(DB)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .sif(bif.slave));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit run_a = 1'b0, run_b = 1'b0;
    int start_a = 0, start_b = 0;

    // Groups released so far: one per full delay period since the start edge.
    function automatic int released(input bit run, input int start, input int now,
                                    input int dly, input int stages);
        int r;
        if (!run) return 0;
        r = (now - start) / dly;
        if (r > stages) r = stages;
        return r;
    endfunction

    function automatic logic [127:0] ones_below(input int n);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 128; i++) if (i < n) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int ra, rb;
        ra = released(run_a, start_a, cyc, DA, SA);
        rb = released(run_b, start_b, cyc, DB, SB);
        chk_vec({tag, "/a.o"}, aif.o, ones_below(min_i(ra * GA, WA)));
        chk_int({tag, "/a.busy"}, int'(aif.busy_o), int'(run_a && ra < SA));
        chk_int({tag, "/a.done"}, int'(aif.done_o), int'(run_a && ra == SA));
        chk_vec({tag, "/b.o"}, {108'b0, bif.o}, ones_below(min_i(rb * GB, WB)));
        chk_int({tag, "/b.busy"}, int'(bif.busy_o), int'(run_b && rb < SB));
        chk_int({tag, "/b.done"}, int'(bif.done_o), int'(run_b && rb == SB));
`ifdef BSG_TIEHI_SEQ_STAGE_OUT_EN
        chk_int({tag, "/a.stage"}, int'(aif.stage_o), ra);
        chk_int({tag, "/b.stage"}, int'(bif.stage_o), rb);
`endif
    endtask

    // One rising edge: advance the model with the inputs seen at the edge, then check.
    task automatic tick(input string tag);
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            run_a = 1'b0;
            run_b = 1'b0;
        end else begin
            if (aif.clear_i) run_a = 1'b0;
            else if (!run_a && aif.en_i) begin run_a = 1'b1; start_a = cyc; end
            if (bif.clear_i) run_b = 1'b0;
            else if (!run_b && bif.en_i) begin run_b = 1'b1; start_b = cyc; end
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic ea, input logic ca, input logic eb, input logic cb);
        aif.en_i = ea; aif.clear_i = ca;
        bif.en_i = eb; bif.clear_i = cb;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check_all("reset");
        tick("reset_hold");
        tick("reset_hold");
        #3 rst_n = 1'b1;

        for (int i = 0; i < 100; i++) tick("idle");

        // Start both instances at edge N and watch the whole release sequence.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick("start");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 70; i++) begin
            tick("seq");
            if (i == 1) chk_vec("b_first", {108'b0, bif.o}, 128'hFF);
            if (i == 2) chk_vec("b_second", {108'b0, bif.o}, 128'hFFFF);
            if (i == 3) begin
                chk_vec("b_third", {108'b0, bif.o}, 128'hFFFFF);
                chk_int("b_done3", int'(bif.done_o), 1);
            end
            if (i == 7)  chk_vec("a_pre_stage0", aif.o, 128'h0);
            if (i == 8)  chk_vec("a_stage0", aif.o, 128'hFFFF);
            if (i == 16) chk_vec("a_stage1", aif.o, 128'hFFFF_FFFF);
            if (i == 63) chk_int("a_not_done63", int'(aif.done_o), 0);
            if (i == 64) begin
                chk_vec("a_all_ones", aif.o, {128{1'b1}});
                chk_int("a_done64", int'(aif.done_o), 1);
            end
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick("en_in_done");

        // Clear mid-sequence, then restart from stage 0.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        tick("clear_done");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick("start2");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) tick("seq2");
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick("clear_mid");
        chk_vec("a_cleared", aif.o, 128'h0);
        chk_int("a_cleared_busy", int'(aif.busy_o), 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick("restart");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) tick("seq3");
        chk_vec("a_restart_stage0", aif.o, 128'hFFFF);

        // en and clear together in IDLE keeps the block idle.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        tick("clear_idle");
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick("en_and_clear");
        chk_int("a_stay_idle", int'(aif.busy_o), 0);
        chk_int("b_stay_idle", int'(bif.busy_o), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick("idle2");

        // Asynchronous reset mid-sequence, then en accepted on the first edge.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        tick("start4");
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) tick("seq4");
        #3 rst_n = 1'b0;
        run_a = 1'b0;
        run_b = 1'b0;
        #1;
        chk_vec("async_rst_o", aif.o, 128'h0);
        check_all("async_rst");
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        tick("first_edge");
        chk_int("a_accept_first", int'(aif.busy_o), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70; i++) tick("seq5");

        // Randomized en/clear traffic.
        for (int i = 0; i < 1500; i++) begin
            drive(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 63) == 0),
                  logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 15) == 0));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
